// File: rtl/usb_pkg.sv
// usb_pkg: shared states, line levels and constants for the USB transmit path
package usb_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} tx_state_t;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;
  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
    return b ? cur : (cur == LINE_J ? LINE_K : LINE_J);
  endfunction
endpackage

// File: rtl/usb_tx_encoder_bit_timer.sv
// usb_bit_timer: rollover counter producing one strobe per USB bit time
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic strobe
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign strobe = cnt == W'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1, restarting on clear so a packet's first bit is full length
  always_ff @(posedge clk)
    if (!n_rst || clear || strobe) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: serialises byte packets as SYNC/payload/EOP with NRZI and bit stuffing
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic       d_plus_out,
  output logic       d_minus_out
);
  tx_state_t state, state_next;
  logic [7:0] hold_data, sr;
  logic [2:0] bit_cnt, cnt_next, ones;
  logic [1:0] line, line_next;
  logic hold_last, hold_full, cur_last, strobe;
  logic accept, start, at_end, stuff_due, boundary, underflow, reload, bit_val;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .n_rst(n_rst),
    .clear(start),
    .strobe(strobe)
  );

  // handshake and byte-boundary decisions shared by the FSM and datapath
  always_comb begin
    accept = tx_valid && !hold_full;
    start = state == IDLE && hold_full;
    at_end = bit_cnt == 3'd7;
    stuff_due = ones == STUFF_LIMIT;
    boundary = strobe && at_end && (state == STUFF || (state == DATA && !stuff_due));
    underflow = boundary && !cur_last && !hold_full;
    reload = start || (boundary && !cur_last && hold_full);
  end

  // state register
  always_ff @(posedge clk)
    if (!n_rst) state <= IDLE;
    else state <= state_next;

  // next state: a pending stuff bit always precedes the byte boundary
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hold_full) state_next = SYNC;
      SYNC:    if (strobe && at_end) state_next = DATA;
      DATA:    if (strobe) state_next = stuff_due ? STUFF : (at_end && (cur_last || !hold_full)) ? EOP_SE0 : DATA;
      STUFF:   if (strobe) state_next = (at_end && (cur_last || !hold_full)) ? EOP_SE0 : DATA;
      EOP_SE0: if (strobe && bit_cnt[0]) state_next = EOP_J;
      EOP_J:   if (strobe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // next bit to drive: index, data value and resulting line level
  always_comb begin
    cnt_next = state_next == STUFF ? bit_cnt : (reload || (state != state_next && state != STUFF)) ? 3'd0 : bit_cnt + 3'd1;
    bit_val = state_next == SYNC ? SYNC_PATTERN[cnt_next] : state_next == STUFF ? 1'b0 : reload ? hold_data[cnt_next] : sr[cnt_next];
    line_next = state_next == EOP_SE0 ? LINE_SE0 : (state_next inside {EOP_J, IDLE}) ? LINE_J : nrzi(line, bit_val);
  end

  // holding register, shift byte, bit counters and registered line
  always_ff @(posedge clk)
    if (!n_rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      sr <= '0;
      cur_last <= 1'b0;
      bit_cnt <= '0;
      ones <= '0;
      line <= LINE_J;
      tx_err <= 1'b0;
    end else begin
      hold_full <= (hold_full && !reload) || accept;
      if (accept) {hold_data, hold_last} <= {tx_data, tx_last};
      if (reload) {sr, cur_last} <= {hold_data, hold_last};
      if (start || (strobe && state != IDLE)) begin
        bit_cnt <= cnt_next;
        ones <= (bit_val && (state_next inside {SYNC, DATA})) ? ones + 3'd1 : 3'd0;
        line <= line_next;
      end
      tx_err <= underflow;
    end

  // outputs
  always_comb begin
    tx_ready = !hold_full;
    tx_busy = state != IDLE;
    {d_plus_out, d_minus_out} = line;
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed checks of line symbols, handshake, stuffing, underflow and reset
module tb_usb_tx_encoder;
  localparam int C = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_busy, tx_err, d_plus_out, d_minus_out;
  int checks = 0;
  int errors = 0;

  usb_tx_encoder #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_err(tx_err),
    .d_plus_out(d_plus_out),
    .d_minus_out(d_minus_out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sym(input byte c);
    return c == "J" ? 2'b10 : c == "K" ? 2'b01 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic line_seq(input string tag, input string s, input int pre, input int err_bit);
    for (int i = 0; i < s.len(); i++)
      for (int j = (i == 0) ? pre : 0; j < C; j++) begin
        @(negedge clk);
        chk($sformatf("%s bit%0d", tag, i), {tx_err, tx_busy, d_plus_out, d_minus_out},
            {(i == err_bit) && (j == 0), 1'b1, sym(s[i])});
      end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tx_valid = 1'b1;
    tx_data = d;
    tx_last = l;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("latency", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0010);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    chk(tag, {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0010);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset line", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0010);
    chk("reset ready", {3'b000, tx_ready}, 4'd1);
    n_rst = 1'b1;
    @(negedge clk);

    send(8'h00, 1'b1);
    line_seq("zero", "KJKJKJKKJKJKJKJKSSJ", 0, -1);
    idle("zero end");

    send(8'hFF, 1'b1);
    line_seq("stuff", "KJKJKJKKKKKKKJJJJSSJ", 0, -1);
    idle("stuff end");

    tx_valid = 1'b1;
    tx_data = 8'hA5;
    tx_last = 1'b0;
    @(negedge clk);
    chk("stream ready1", {3'b000, tx_ready}, 4'd0);
    tx_data = 8'h3C;
    tx_last = 1'b1;
    @(negedge clk);
    chk("stream ready2", {3'b000, tx_ready}, 4'd1);
    chk("stream first", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0101);
    @(negedge clk);
    chk("stream ready3", {3'b000, tx_ready}, 4'd0);
    tx_valid = 1'b0;
    line_seq("stream", "KJKJKJKKKJJKJJKKJKKKKKJKSSJ", 2, -1);
    idle("stream end");

    send(8'h12, 1'b0);
    line_seq("underflow", "KJKJKJKKJJKJJKJKSSJ", 0, 16);
    idle("underflow end");

    send(8'h10, 1'b1);
    line_seq("rst pre", "KJKJKJKKJKJK", 0, -1);
    @(negedge clk);
    chk("rst bit4", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0101);
    tx_valid = 1'b1;
    tx_data = 8'h55;
    tx_last = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst line", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0010);
    chk("rst ready", {3'b000, tx_ready}, 4'd1);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst quiet", {tx_err, tx_busy, d_plus_out, d_minus_out}, 4'b0010);
    send(8'h00, 1'b1);
    line_seq("after rst", "KJKJKJKKJKJKJKJKSSJ", 0, -1);
    idle("after rst end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
